// File: rtl/morse_letter_decoder.sv
// Collects dot/dash symbols into a letter, closes it after GAP_TICKS idle ticks
// and emits the ITU Morse A-Z decode as ASCII, flagging unknown or overlong patterns.
module morse_letter_decoder #(
    parameter int unsigned GAP_TICKS = 3
) (
    input  logic       CLKin,
    input  logic       rst,
    input  logic       tick,
    input  logic       sym_valid,
    input  logic       sym_bit,
    output logic       char_valid,
    output logic [7:0] char_code,
    output logic       char_err,
    output logic       busy
);

    localparam logic [7:0] QMARK = 8'h3F;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_sym_buf;
    logic [2:0] r_sym_cnt;
    logic [3:0] r_gap_cnt;
    logic       r_ovf;
    logic       r_char_valid;
    logic [7:0] r_char_code;
    logic       r_char_err;
    logic       r_busy;

    logic       w_start;
    logic [3:0] w_gap_next;
    logic [7:0] w_lut_code;
    logic       w_lut_err;

    // Key is {length, symbols}; first symbol sits in bit 0 and unused bits stay 0.
    always_comb begin
        w_lut_code = QMARK;
        case ({r_sym_cnt, r_sym_buf})
            7'b001_0000: w_lut_code = 8'h45; // E
            7'b001_0001: w_lut_code = 8'h54; // T
            7'b010_0000: w_lut_code = 8'h49; // I
            7'b010_0010: w_lut_code = 8'h41; // A
            7'b010_0001: w_lut_code = 8'h4E; // N
            7'b010_0011: w_lut_code = 8'h4D; // M
            7'b011_0000: w_lut_code = 8'h53; // S
            7'b011_0100: w_lut_code = 8'h55; // U
            7'b011_0010: w_lut_code = 8'h52; // R
            7'b011_0110: w_lut_code = 8'h57; // W
            7'b011_0001: w_lut_code = 8'h44; // D
            7'b011_0101: w_lut_code = 8'h4B; // K
            7'b011_0011: w_lut_code = 8'h47; // G
            7'b011_0111: w_lut_code = 8'h4F; // O
            7'b100_0000: w_lut_code = 8'h48; // H
            7'b100_1000: w_lut_code = 8'h56; // V
            7'b100_0100: w_lut_code = 8'h46; // F
            7'b100_0010: w_lut_code = 8'h4C; // L
            7'b100_0110: w_lut_code = 8'h50; // P
            7'b100_1110: w_lut_code = 8'h4A; // J
            7'b100_0001: w_lut_code = 8'h42; // B
            7'b100_1001: w_lut_code = 8'h58; // X
            7'b100_0101: w_lut_code = 8'h43; // C
            7'b100_1101: w_lut_code = 8'h59; // Y
            7'b100_0011: w_lut_code = 8'h5A; // Z
            7'b100_1011: w_lut_code = 8'h51; // Q
            default:     w_lut_code = QMARK;
        endcase
        if (r_ovf) begin
            w_lut_code = QMARK;
        end
        w_lut_err = (w_lut_code == QMARK);
    end

    assign w_start    = sym_valid && ((r_state == S_IDLE) || (r_state == S_EMIT));
    assign w_gap_next = r_gap_cnt + 4'd1;

    always_ff @(posedge CLKin) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sym_buf    <= 4'd0;
            r_sym_cnt    <= 3'd0;
            r_gap_cnt    <= 4'd0;
            r_ovf        <= 1'b0;
            r_char_valid <= 1'b0;
            r_char_code  <= 8'h00;
            r_char_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_char_valid <= 1'b0;
            if (w_start) begin
                r_state   <= S_COLLECT;
                r_sym_buf <= {3'b000, sym_bit};
                r_sym_cnt <= 3'd1;
                r_gap_cnt <= 4'd0;
                r_ovf     <= 1'b0;
                r_busy    <= 1'b1;
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        // A symbol beats a coincident tick: store it and restart the gap.
                        if (sym_valid) begin
                            if (r_sym_cnt == 3'd4) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_sym_buf[r_sym_cnt[1:0]] <= sym_bit;
                                r_sym_cnt                 <= r_sym_cnt + 3'd1;
                            end
                            r_gap_cnt <= 4'd0;
                        end else if (tick) begin
                            if (w_gap_next == 4'(GAP_TICKS)) begin
                                r_state      <= S_EMIT;
                                r_char_valid <= 1'b1;
                                r_char_code  <= w_lut_code;
                                r_char_err   <= w_lut_err;
                                r_busy       <= 1'b0;
                                r_gap_cnt    <= 4'd0;
                            end else begin
                                r_gap_cnt <= w_gap_next;
                            end
                        end
                    end
                    S_EMIT: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign char_valid = r_char_valid;
    assign char_code  = r_char_code;
    assign char_err   = r_char_err;
    assign busy       = r_busy;

endmodule

// File: doc/morse_letter_decoder.md
MORSE_LETTER_DECODER -- requirements
Module: morse_letter_decoder

Interface
REQ-001 Parameter GAP_TICKS, default 3: number of consecutive tick pulses with no symbol that closes a letter; legal range 1-15.
REQ-002 CLKin  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tick  input  1  timing enable, one-CLKin-cycle pulse at the slow symbol rate (1 Hz on the board).
REQ-005 sym_valid  input  1  one-cycle pulse: a symbol was entered this cycle.
REQ-006 sym_bit  input  1  symbol value, sampled only when sym_valid=1; 0=dot, 1=dash.
REQ-007 char_valid  output  1  one-cycle pulse: char_code/char_err updated this cycle.
REQ-008 char_code  output  8  ASCII of the decoded letter, held until the next char_valid.
REQ-009 char_err  output  1  1 = last emitted letter was invalid; held with char_code.
REQ-010 busy  output  1  1 while a letter is being collected (state COLLECT).

Function
REQ-011 The FSM SHALL have states IDLE, COLLECT and EMIT.
REQ-012 The internal state SHALL comprise: sym_buf[3:0], with the first symbol in bit 0; sym_cnt 0-4; gap_cnt 4 bits; ovf flag.
REQ-013 In IDLE, sym_valid=1 SHALL store sym_bit into sym_buf[0], set sym_cnt=1, gap_cnt=0, ovf=0, and go to COLLECT next cycle.
REQ-014 In IDLE, tick SHALL be ignored.
REQ-015 In COLLECT, when sym_valid=1 and sym_cnt<4, the block SHALL store sym_bit into sym_buf[sym_cnt], increment sym_cnt and clear gap_cnt.
REQ-016 In COLLECT, when sym_valid=1 and sym_cnt=4, the block SHALL set ovf=1, clear gap_cnt, and leave sym_buf and sym_cnt unchanged (the symbol is discarded).
REQ-017 In COLLECT, when tick=1 and sym_valid=0, gap_cnt SHALL increment.
REQ-018 When the incremented gap_cnt equals GAP_TICKS, the next state SHALL be EMIT.
REQ-019 When tick and sym_valid are both 1 in the same cycle, the symbol SHALL win: the symbol is stored and gap_cnt is cleared, with no increment.
REQ-020 EMIT SHALL last exactly one cycle and SHALL drive char_valid=1.
REQ-021 In EMIT, char_code and char_err SHALL be registered from the lookup of (sym_cnt, sym_buf[sym_cnt-1:0]).
REQ-022 The lookup SHALL be the ITU Morse table for A-Z, uppercase ASCII 0x41-0x5A.
REQ-023 Patterns not assigned to a letter (..--, .-.-, ---., ----), or any letter with ovf=1, SHALL produce char_code=0x3F ('?') and char_err=1.
REQ-024 A valid letter SHALL produce char_err=0.
REQ-025 Latency SHALL be: char_valid asserts on the cycle after the tick that completes the gap.
REQ-026 In EMIT, sym_valid=1 SHALL start a new letter exactly as in IDLE (REQ-013), and the next state SHALL be COLLECT; otherwise the next state SHALL be IDLE.
REQ-027 busy SHALL be 1 only in COLLECT.
REQ-028 char_valid SHALL be 0 in every state other than EMIT.
REQ-029 The block SHALL apply no debounce and no edge detection; sym_valid is assumed already single-cycle from the upstream button stage.

Reset
REQ-030 While rst=1, on each rising edge of CLKin: state<=IDLE, sym_buf<=0, sym_cnt<=0, gap_cnt<=0, ovf<=0, char_valid<=0, char_code<=0x00, char_err<=0, busy<=0.
REQ-031 rst SHALL have priority over sym_valid and tick in the same cycle.
REQ-032 Reset during COLLECT or EMIT SHALL abandon the partial letter with no char_valid pulse.

Verification
REQ-033 Dot, dash (sym_bit 0 then 1), then 3 ticks (GAP_TICKS=3) -> one char_valid pulse one cycle after the 3rd tick; char_code=0x41, char_err=0; busy 1->0.
REQ-034 Symbols dash, dot, dot, dot, then gap -> char_code=0x42 ('B'), char_err=0; a single dash then gap -> 0x54 ('T').
REQ-035 Five dots, then gap -> sym_cnt stays 4 and ovf=1; output char_code=0x3F, char_err=1; the next letter, a single dot, decodes to 0x45 ('E') with char_err=0.
REQ-036 Dot, then tick+sym_valid(dash) in the same cycle, then 2 ticks -> no emit yet; the 3rd tick emits 0x41 (gap counter was cleared, not incremented).
REQ-037 Symbols dot, dot, dash, dash, then gap -> char_code=0x3F, char_err=1.
REQ-038 rst asserted one cycle mid-COLLECT after two symbols -> no char_valid pulse; all outputs at reset values; subsequent ticks in IDLE produce no output.
